branch_counter: RTL

BRANCH_COUNTER -- requirements
Module: branch_counter

---
 rtl/branch_counter_pkg.sv | 11 +
 rtl/branch_counter_entry.sv | 43 ++++
 rtl/branch_counter.sv | 81 ++++++++
 3 files changed

// File: rtl/branch_counter_pkg.sv
// branch_counter_pkg
// Shared sizing constants for the per-thread branch loop counter. The
// condition predicate and the thread-number stage import the same values,
// so every stage agrees on the word and thread-id widths.
package branch_counter_pkg;

  localparam int DEFAULT_WORD_WIDTH        = 36;
  localparam int DEFAULT_THREAD_COUNT      = 8;
  localparam int DEFAULT_THREAD_ADDR_WIDTH = 3;

endpackage

// File: rtl/branch_counter_entry.sv
// branch_counter_entry
// One thread's loop counter: a count register and a reload register.
// Ports:
//   clock, reset_n - rising-edge clock, asynchronous active-low reset
//   load           - take load_data into both count and reload
//   load_data      - new reload value
//   step           - decrement the count, reloading it when already zero
//   running        - combinational: count is nonzero
module branch_counter_entry
  import branch_counter_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_data,
  input  logic                  step,
  output logic                  running
);

  logic [WORD_WIDTH-1:0] count_q;
  logic [WORD_WIDTH-1:0] reload_q;

  assign running = (count_q != '0);

  // Load has priority over step; the top also masks step on a same-thread
  // write, so this ordering is only a second line of defence.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      reload_q <= '0;
    end else if (load) begin
      count_q  <= load_data;
      reload_q <= load_data;
    end else if (step) begin
      // Stepping at zero rearms the loop instead of wrapping.
      if (running) count_q <= count_q - 1'b1;
      else         count_q <= reload_q;
    end
  end

endmodule

// File: rtl/branch_counter.sv
// branch_counter
// Per-thread loop counters feeding the B-group counter input of the
// branch condition predicate.
// Ports:
//   clock, reset_n   - rising-edge clock, asynchronous active-low reset
//   current_thread   - thread examined this cycle
//   decrement        - step current_thread's counter
//   write_enable     - software load of write_thread's counter
//   write_thread     - target thread of the load
//   write_data       - value loaded into both reload and count
//   counter_running  - registered: examined count was nonzero
//   counter_thread   - registered: thread that counter_running refers to
//
// Timing contract: current_thread/decrement/write_* are sampled on a rising
// edge; counter_running and counter_thread present the result of that
// sample after the same edge, reflecting the count as it stood before the
// edge's own update. There is no back-pressure; every cycle is a sample.
module branch_counter
  import branch_counter_pkg::*;
#(
  parameter int WORD_WIDTH        = DEFAULT_WORD_WIDTH,
  parameter int THREAD_COUNT      = DEFAULT_THREAD_COUNT,
  parameter int THREAD_ADDR_WIDTH = DEFAULT_THREAD_ADDR_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [THREAD_ADDR_WIDTH-1:0] current_thread,
  input  logic                         decrement,
  input  logic                         write_enable,
  input  logic [THREAD_ADDR_WIDTH-1:0] write_thread,
  input  logic [WORD_WIDTH-1:0]        write_data,
  output logic                         counter_running,
  output logic [THREAD_ADDR_WIDTH-1:0] counter_thread
);

  localparam logic [THREAD_ADDR_WIDTH:0] THREAD_LIMIT =
    THREAD_COUNT[THREAD_ADDR_WIDTH:0];

  logic [THREAD_COUNT-1:0] entry_running;
  logic                    current_valid;
  logic                    selected_running;

  for (genvar i = 0; i < THREAD_COUNT; i++) begin : g_entry
    logic load;
    logic step;

    // A write to this thread discards a coinciding decrement.
    assign load = write_enable && (write_thread == THREAD_ADDR_WIDTH'(i));
    assign step = decrement && (current_thread == THREAD_ADDR_WIDTH'(i)) && !load;

    branch_counter_entry #(
      .WORD_WIDTH (WORD_WIDTH)
    ) u_entry (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (load),
      .load_data (write_data),
      .step      (step),
      .running   (entry_running[i])
    );
  end

  // Thread ids past THREAD_COUNT have no entry and read as not-running.
  assign current_valid = ({1'b0, current_thread} < THREAD_LIMIT);

  always_comb begin
    selected_running = 1'b0;
    if (current_valid) selected_running = entry_running[current_thread];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter_running <= 1'b0;
      counter_thread  <= '0;
    end else begin
      counter_running <= selected_running;
      counter_thread  <= current_thread;
    end
  end

endmodule
